load_store_unit: RTL and testbench

- Sits directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address for loads and stores and drives a ready-handshaked data-memory port.
- Forms the byte enables and lane-aligned store data, then sign- or zero-extends load data before writeback.
- Stalls the core while an access is outstanding and reports misalignment, illegal funct3 and bus-timeout errors.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns an ALU effective address into a ready-handshaked
// data-memory access, with lane steering, load extension and fault reporting.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic [1:0]  lsu_err_code,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_MISALGN = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;
   localparam logic [1:0] CODE_ILLEGAL = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             store_q, store_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [1:0]       code_q, code_d;

   logic             f3_legal;
   logic             misaligned;
   logic [3:0]       be_new;
   logic [31:0]      wdata_new;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_ext;
   logic             timeout_hit;

   // funct3[1:0] encodes the access size for both loads and stores.
   always_comb begin
      if (req_store) begin
         f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      end else begin
         f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
      end
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = req_wdata;
      if (req_store) begin
         case (req_funct3[1:0])
            2'b00: begin
               be_new    = 4'b0001 << req_addr[1:0];
               wdata_new = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
               wdata_new = {2{req_wdata[15:0]}};
            end
            default: begin
               be_new    = 4'b1111;
               wdata_new = req_wdata;
            end
         endcase
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   ld_byte = mem_rdata[7:0];
         2'b01:   ld_byte = mem_rdata[15:8];
         2'b10:   ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'b0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'b0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      code_d   = code_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               be_d     = be_new;
               wdata_d  = wdata_new;
               rdata_d  = 32'b0;
               cnt_d    = '0;
               // Illegal funct3 is reported ahead of misalignment.
               if (!f3_legal) begin
                  state_d = DONE;
                  code_d  = CODE_ILLEGAL;
               end else if (misaligned) begin
                  state_d = DONE;
                  code_d  = CODE_MISALGN;
               end else begin
                  state_d = REQ;
                  code_d  = CODE_NONE;
               end
            end
         end
         REQ: begin
            if (mem_ready) begin
               state_d = DONE;
               rdata_d = store_q ? 32'b0 : ld_ext;
               code_d  = CODE_NONE;
            end else if (timeout_hit) begin
               state_d = DONE;
               rdata_d = 32'b0;
               code_d  = CODE_TIMEOUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         store_q  <= 1'b0;
         funct3_q <= 3'b0;
         addr_q   <= 32'b0;
         be_q     <= 4'b0;
         wdata_q  <= 32'b0;
         rdata_q  <= 32'b0;
         code_q   <= CODE_NONE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         code_q   <= code_d;
      end
   end

   // Memory-side outputs are forced to zero outside REQ so the bus idles cleanly.
   always_comb begin
      mem_req      = (state_q == REQ);
      mem_we       = mem_req & store_q;
      mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
      mem_be       = mem_req ? be_q : 4'b0;
      mem_wdata    = mem_req ? wdata_q : 32'b0;
      lsu_done     = (state_q == DONE);
      lsu_stall    = mem_req | ((state_q == IDLE) & req_valid);
      lsu_rdata    = lsu_done ? rdata_q : 32'b0;
      lsu_err_code = lsu_done ? code_q : CODE_NONE;
      lsu_err      = lsu_done & (code_q != CODE_NONE);
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit, built with a short timeout
// so bus-timeout behaviour is reachable in a few cycles.
module tb_load_store_unit;

   localparam int MNORM  = 0;
   localparam int MFAULT = 1;
   localparam int MTO    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        lsu_stall;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic [1:0]  lsu_err_code;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   load_store_unit #(
      .TIMEOUT_CYCLES(4),
      .CNT_W         (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_store   (req_store),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .lsu_stall   (lsu_stall),
      .lsu_done    (lsu_done),
      .lsu_rdata   (lsu_rdata),
      .lsu_err     (lsu_err),
      .lsu_err_code(lsu_err_code),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".done"},  {31'b0, lsu_done}, 32'd0);
      check({tag, ".err"},   {31'b0, lsu_err}, 32'd0);
      check({tag, ".code"},  {30'b0, lsu_err_code}, 32'd0);
      check({tag, ".rdata"}, lsu_rdata, 32'd0);
      check({tag, ".mreq"},  {31'b0, mem_req}, 32'd0);
      check({tag, ".be"},    {28'b0, mem_be}, 32'd0);
   endtask

   // One full access. MNORM: ready on REQ cycle number waits+1. MFAULT: no REQ.
   // MTO: ready held low for waits REQ cycles, then the timeout fires.
   task automatic access(input string tag, input int mode, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int waits,
                         input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] erd, input logic [1:0] ecode);
      int nreq;
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      mem_ready  = 1'b0;
      #1;
      check({tag, ".req_stall"}, {31'b0, lsu_stall}, 32'd1);
      check({tag, ".req_mreq"},  {31'b0, mem_req}, 32'd0);
      nreq = (mode == MFAULT) ? 0 : (mode == MTO) ? waits : waits + 1;
      for (int i = 0; i < nreq; i++) begin
         @(negedge clk);
         if (mode == MNORM && i == waits) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
         end else begin
            mem_rdata = 32'h5A5A_C3C3;
         end
         #1;
         check({tag, ".mreq"},  {31'b0, mem_req}, 32'd1);
         check({tag, ".we"},    {31'b0, mem_we}, {31'b0, st});
         check({tag, ".maddr"}, mem_addr, {a[31:2], 2'b00});
         check({tag, ".be"},    {28'b0, mem_be}, {28'b0, ebe});
         if (st) check({tag, ".wdata"}, mem_wdata, ewd);
         check({tag, ".stall"}, {31'b0, lsu_stall}, 32'd1);
         check({tag, ".nodone"}, {31'b0, lsu_done}, 32'd0);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      check({tag, ".done"},  {31'b0, lsu_done}, 32'd1);
      check({tag, ".stall"}, {31'b0, lsu_stall}, 32'd0);
      check({tag, ".mreq"},  {31'b0, mem_req}, 32'd0);
      check({tag, ".err"},   {31'b0, lsu_err}, {31'b0, (ecode != 2'b00)});
      check({tag, ".code"},  {30'b0, lsu_err_code}, {30'b0, ecode});
      check({tag, ".rdata"}, lsu_rdata, erd);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      check_idle({tag, ".after"});
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'b0;
      req_wdata  = 32'b0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_idle("reset");
      check("reset.stall", {31'b0, lsu_stall}, 32'd0);
      check("reset.wdata", mem_wdata, 32'd0);
      check("reset.maddr", mem_addr, 32'd0);
      rst = 1'b0;

      // Stores
      access("sw_wait3", MNORM, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 3, 32'h0,
             4'b1111, 32'hDEAD_BEEF, 32'h0, 2'b00);
      access("sb_103", MNORM, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 32'h0,
             4'b1000, 32'hA5A5_A5A5, 32'h0, 2'b00);
      access("sh_102", MNORM, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 0, 32'h0,
             4'b1100, 32'h1234_1234, 32'h0, 2'b00);
      access("sh_100", MNORM, 1'b1, 3'b001, 32'h0000_0100, 32'hFFFF_5678, 1, 32'h0,
             4'b0011, 32'h5678_5678, 32'h0, 2'b00);

      // Loads against one fixed memory word
      access("lb_1",  MNORM, 1'b0, 3'b000, 32'h1, 32'h0, 0, 32'h80F1_7F02,
             4'b1111, 32'h0, 32'h0000_007F, 2'b00);
      access("lb_2",  MNORM, 1'b0, 3'b000, 32'h2, 32'h0, 0, 32'h80F1_7F02,
             4'b1111, 32'h0, 32'hFFFF_FFF1, 2'b00);
      access("lbu_3", MNORM, 1'b0, 3'b100, 32'h3, 32'h0, 0, 32'h80F1_7F02,
             4'b1111, 32'h0, 32'h0000_0080, 2'b00);
      access("lh_2",  MNORM, 1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h80F1_7F02,
             4'b1111, 32'h0, 32'hFFFF_80F1, 2'b00);
      access("lhu_0", MNORM, 1'b0, 3'b101, 32'h0, 32'h0, 0, 32'h80F1_7F02,
             4'b1111, 32'h0, 32'h0000_7F02, 2'b00);
      access("lw_0",  MNORM, 1'b0, 3'b010, 32'h0, 32'h0, 0, 32'h80F1_7F02,
             4'b1111, 32'h0, 32'h80F1_7F02, 2'b00);

      // Faults
      access("lw_mis",  MFAULT, 1'b0, 3'b010, 32'h6, 32'h0, 0, 32'h0,
             4'b0000, 32'h0, 32'h0, 2'b01);
      access("lh_ill",  MFAULT, 1'b0, 3'b011, 32'h5, 32'h0, 0, 32'h0,
             4'b0000, 32'h0, 32'h0, 2'b11);
      access("sh_mis",  MFAULT, 1'b1, 3'b001, 32'h3, 32'h0, 0, 32'h0,
             4'b0000, 32'h0, 32'h0, 2'b01);
      access("st_ill",  MFAULT, 1'b1, 3'b100, 32'h0, 32'h0, 0, 32'h0,
             4'b0000, 32'h0, 32'h0, 2'b11);

      // Timeout, then ready landing on the threshold cycle
      access("lw_to", MTO, 1'b0, 3'b010, 32'h40, 32'h0, 4, 32'h0,
             4'b1111, 32'h0, 32'h0, 2'b10);
      access("lw_rdy4", MNORM, 1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h1234_5678,
             4'b1111, 32'h0, 32'h1234_5678, 2'b00);

      // Reset in the second REQ cycle abandons the access
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0080;
      mem_ready  = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid.req1", {31'b0, mem_req}, 32'd1);
      @(negedge clk);
      #1;
      check("rst_mid.req2", {31'b0, mem_req}, 32'd1);
      rst       = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      check_idle("rst_mid.out");
      check("rst_mid.stall", {31'b0, lsu_stall}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_idle("rst_mid.quiet");

      access("sw_post_rst", MNORM, 1'b1, 3'b010, 32'h0000_2008, 32'hCAFE_F00D, 0, 32'h0,
             4'b1111, 32'hCAFE_F00D, 32'h0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
